// File: rtl/regime_watchdog.sv
// Watchdog that consumes eigenvalue-core results, debounces the damping regime and
// raises sticky oscillation, malformed/overrun-result and busy-timeout flags.
module regime_watchdog #(
    parameter int                 PERSIST   = 4,
    parameter int                 TIMEOUT   = 1024,
    parameter logic signed [31:0] KAPPA_LIM = 32'sh0001_0000,
    parameter int                 CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             core_busy,
    input  logic [2:0]       regime,
    input  logic [31:0]      kappa,
    input  logic [31:0]      inv_kappa,
    input  logic             clr_alarm,
    output logic [2:0]       stable_regime,
    output logic             regime_chg,
    output logic [31:0]      kappa_hold,
    output logic [31:0]      inv_kappa_hold,
    output logic             osc_alarm,
    output logic             fault,
    output logic             timeout,
    output logic [CNT_W-1:0] result_cnt
);

    typedef enum logic [1:0] {
        S_WAIT,
        S_EVAL,
        S_COMMIT
    } state_t;

    localparam logic [CNT_W-1:0] PERSIST_C = CNT_W'(PERSIST);
    localparam logic [CNT_W-1:0] TMO_LAST  = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

    state_t             state_reg;
    logic               busy_q;
    logic [2:0]         cap_regime;
    logic [31:0]        cap_kappa;
    logic [31:0]        cap_inv_kappa;
    logic [2:0]         cand;
    logic [CNT_W-1:0]   run_cnt;
    logic [CNT_W-1:0]   tmo_cnt;

    logic               evt;
    logic               cap_onehot;
    logic               commit_chg;
    logic [2:0]         new_stable;
    logic               osc_set;
    logic               fault_set;
    logic               tmo_set;

    always_comb begin
        evt        = ena & busy_q & ~core_busy;
        cap_onehot = (cap_regime == 3'b001) || (cap_regime == 3'b010) || (cap_regime == 3'b100);
        commit_chg = (run_cnt >= PERSIST_C) && (cand != stable_regime);
        new_stable = commit_chg ? cand : stable_regime;
        // The alarm looks at the regime as it will be after this commit, not the old one.
        osc_set    = (state_reg == S_COMMIT) && (new_stable == 3'b001) &&
                     ($signed(cap_kappa) >= KAPPA_LIM);
        fault_set  = ((state_reg == S_EVAL) && !cap_onehot) ||
                     (evt && (state_reg != S_WAIT));
        tmo_set    = core_busy && (tmo_cnt == TMO_LAST);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= S_WAIT;
            busy_q         <= 1'b1;
            cap_regime     <= 3'b000;
            cap_kappa      <= 32'd0;
            cap_inv_kappa  <= 32'd0;
            cand           <= 3'b000;
            run_cnt        <= '0;
            tmo_cnt        <= '0;
            stable_regime  <= 3'b000;
            regime_chg     <= 1'b0;
            kappa_hold     <= 32'd0;
            inv_kappa_hold <= 32'd0;
            osc_alarm      <= 1'b0;
            fault          <= 1'b0;
            timeout        <= 1'b0;
            result_cnt     <= '0;
        end else begin
            regime_chg <= 1'b0;
            if (ena) begin
                busy_q <= core_busy;

                if (core_busy) begin
                    if (tmo_cnt != CNT_MAX)
                        tmo_cnt <= tmo_cnt + 1'b1;
                end else begin
                    tmo_cnt <= '0;
                end

                // Set has priority over a simultaneous clear.
                osc_alarm <= osc_set   | (osc_alarm & ~clr_alarm);
                fault     <= fault_set | (fault     & ~clr_alarm);
                timeout   <= tmo_set   | (timeout   & ~clr_alarm);

                case (state_reg)
                    S_WAIT: begin
                        if (evt) begin
                            cap_regime    <= regime;
                            cap_kappa     <= kappa;
                            cap_inv_kappa <= inv_kappa;
                            state_reg     <= S_EVAL;
                        end
                    end
                    S_EVAL: begin
                        if (!cap_onehot) begin
                            state_reg <= S_WAIT;
                        end else begin
                            if (cap_regime == cand) begin
                                if (run_cnt != CNT_MAX)
                                    run_cnt <= run_cnt + 1'b1;
                            end else begin
                                cand    <= cap_regime;
                                run_cnt <= {{(CNT_W-1){1'b0}}, 1'b1};
                            end
                            state_reg <= S_COMMIT;
                        end
                    end
                    S_COMMIT: begin
                        kappa_hold     <= cap_kappa;
                        inv_kappa_hold <= cap_inv_kappa;
                        result_cnt     <= result_cnt + 1'b1;
                        if (commit_chg) begin
                            stable_regime <= cand;
                            regime_chg    <= 1'b1;
                        end
                        state_reg <= S_WAIT;
                    end
                    default: state_reg <= S_WAIT;
                endcase
            end
        end
    end

endmodule
